vga_mem_arbiter: RTL and testbench
==================================

VGA_MEM_ARBITER -- requirements
Module: vga_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, meaning pixel RAM address width (160x120 = 19200 words).
REQ-002 SHALL have parameter DATA_W, default 8, meaning pixel colour width.
REQ-003 SHALL have parameter CLR_COLOR, default 0, meaning the value written during a clear sweep.
REQ-004 SHALL have parameter DEPTH, default 19200, meaning the number of words swept by a clear.
REQ-005 Ports (name  direction  width  meaning), clock and reset first:
  CLK  in  1  pixel clock; single clock domain; all logic on rising edge.
  RST_N  in  1  asynchronous, active-low reset.
  disp_req  in  1  scan-out needs a pixel this cycle.
  disp_addr  in  ADDR_W  scan-out pixel address.
  disp_data  out  DATA_W  returned scan-out pixel.
  disp_dv  out  1  disp_data valid.
  wr_valid / wr_ready  in / out  1  drawing-engine write handshake.
  wr_addr, wr_data  in  ADDR_W, DATA_W  write address and data.
  rd_valid / rd_ready  in / out  1  game-logic read handshake.
  rd_addr  in  ADDR_W  read address.
  rd_data  out  DATA_W  game-logic read data.
  rd_dv  out  1  rd_data valid.
  clr_start  in  1  pulse to start a clear sweep.
  busy  out  1  clear sweep in progress.
  mem_addr, mem_we, mem_wdata  out  ADDR_W, 1, DATA_W  single-port RAM command.
  mem_rdata  in  DATA_W  RAM read data, 1-cycle synchronous latency.

Function
REQ-006 SHALL issue exactly one RAM access per cycle, chosen by fixed priority: display > clear > round-robin(write, read).
REQ-007 SHALL service disp_req in the same cycle it is asserted (mem_addr=disp_addr, mem_we=0), with no stall ever.
REQ-008 SHALL assert disp_dv and drive disp_data=mem_rdata exactly 2 cycles after disp_req (1 RAM cycle + 1 output register).
REQ-009 SHALL assert wr_ready only in a cycle where the write is granted; a transfer occurs when wr_valid & wr_ready; mem_we=1 that cycle.
REQ-010 SHALL assert rd_ready only in a cycle where the read is granted; rd_dv and rd_data follow 2 cycles after the handshake.
REQ-011 SHALL combinationally drop wr_ready and rd_ready in any cycle with disp_req=1 or state CLEAR.
REQ-012 SHALL alternate round-robin between write and read when both are valid; the last-granted pointer updates only on a completed handshake.
REQ-013 SHALL carry a 2-stage owner tag (NONE/DISP/RD) alongside each read so that data returns to the correct requester.
REQ-014 SHALL implement the FSM states IDLE and CLEAR.
REQ-015 In IDLE, clr_start=1 SHALL move the FSM to CLEAR with clr_ptr=0 and busy=1 on the next cycle.
REQ-016 In CLEAR, each cycle without disp_req SHALL write CLR_COLOR to clr_ptr and then increment clr_ptr.
REQ-017 In CLEAR, a cycle with disp_req SHALL leave clr_ptr unchanged, so the display preempts the clear.
REQ-018 The FSM SHALL return from CLEAR to IDLE after the write at clr_ptr=DEPTH-1; busy SHALL be 0 in the cycle after that final write.
REQ-019 SHALL ignore clr_start while in CLEAR, so the sweep does not restart.
REQ-020 SHALL hold wr_valid requests pending during CLEAR; they are not dropped (requester holds wr_valid).
REQ-021 SHALL never drive mem_we=1 for any address >= DEPTH; out-of-range wr_addr is granted, but no RAM write occurs.

Reset
REQ-022 On RST_N=0, SHALL immediately force: state=IDLE, clr_ptr=0, busy=0, wr_ready=0, rd_ready=0, disp_dv=0, rd_dv=0, disp_data=0, rd_data=0, mem_we=0, mem_addr=0, owner tags=NONE, RR pointer=write-first.
REQ-023 Reset asserted mid-clear SHALL abandon the sweep; after release the FSM stays in IDLE until a new clr_start.
REQ-024 In-flight reads at reset SHALL be discarded, with no dv pulse after release.

Structure
REQ-025 A shared package SHALL hold the owner-tag encoding (NONE/DISP/RD), the FSM state encoding, and the default ADDR_W/DATA_W/DEPTH constants.
REQ-026 The round-robin grant between write and read SHALL be one sub-module, rr_arb2.
REQ-027 The RAM itself SHALL be external to this block.

Verification
REQ-028 Only disp_req every 4th cycle, addr 0x0010, RAM holds 0xA5 -> disp_dv 2 cycles later, disp_data=0xA5, no gaps.
REQ-029 wr_valid and rd_valid held together, display idle -> grants alternate W,R,W,R starting with W; rd_dv lags each R grant by 2 cycles.
REQ-030 disp_req=1 continuously for 10 cycles with wr_valid=1 -> wr_ready=0 for all 10 cycles, write completes on cycle 11.
REQ-031 clr_start with DEPTH=16 and disp_req on 4 interleaved cycles -> exactly 16 writes of CLR_COLOR to 0..15; busy high for 20 cycles.
REQ-032 RST_N low at clr_ptr=7 -> all outputs reset immediately; no further mem_we; busy=0.
REQ-033 wr_addr=DEPTH -> wr_ready handshake completes, mem_we stays 0.

Source files
------------

// File: rtl/vga_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_mem_arbiter_pkg
//  Description : Shared types and default constants for the VGA pixel-RAM
//                arbiter: read-owner tag encoding, FSM state encoding and
//                default geometry (160x120 frame of 8-bit pixels).
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_mem_arbiter_pkg;

    // Default geometry: 160x120 = 19200 pixels fits in a 15-bit address.
    localparam int c_ADDR_W_DEF = 15;
    localparam int c_DATA_W_DEF = 8;
    localparam int c_DEPTH_DEF  = 19200;

    // Identifies which requester a RAM read in flight belongs to.
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_RD   = 2'd2
    } owner_tag_e;

    // Arbiter control states.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

endpackage : vga_mem_arbiter_pkg
`default_nettype wire

// File: rtl/vga_mem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way round-robin grant between the drawing-engine write
//                port and the game-logic read port. A single request is
//                granted directly; when both request, the side that was not
//                granted last wins. The preference flips only when a grant is
//                actually issued (grant implies request, i.e. a handshake).
//  Ports       : clk_i     - clock
//                rst_ni    - asynchronous active-low reset
//                en_i      - arbitration allowed this cycle
//                wr_req_i  - write request (wr_valid)
//                rd_req_i  - read request (rd_valid)
//                wr_gnt_o  - write granted this cycle
//                rd_gnt_o  - read granted this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic wr_req_i,
    input  logic rd_req_i,
    output logic wr_gnt_o,
    output logic rd_gnt_o
);

    // 0: write preferred on conflict, 1: read preferred on conflict.
    logic prio_rd_q;
    logic prio_rd_d;
    logic w_wr_gnt;
    logic w_rd_gnt;

    always_comb begin
        w_wr_gnt = 1'b0;
        w_rd_gnt = 1'b0;
        if (en_i) begin
            if (wr_req_i && rd_req_i) begin
                w_wr_gnt = ~prio_rd_q;
                w_rd_gnt = prio_rd_q;
            end else begin
                w_wr_gnt = wr_req_i;
                w_rd_gnt = rd_req_i;
            end
        end
    end

    always_comb begin
        prio_rd_d = prio_rd_q;
        if (w_wr_gnt) begin
            prio_rd_d = 1'b1;
        end else if (w_rd_gnt) begin
            prio_rd_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_rd_q <= 1'b0;
        end else begin
            prio_rd_q <= prio_rd_d;
        end
    end

    assign wr_gnt_o = w_wr_gnt;
    assign rd_gnt_o = w_rd_gnt;

endmodule : rr_arb2
`default_nettype wire

// File: rtl/vga_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vga_mem_arbiter
//  Description : Single-port pixel-RAM arbiter. One RAM access per cycle with
//                fixed priority display > clear sweep > round-robin(write,
//                read). Display requests are never stalled. Reads return two
//                cycles after issue through a registered output, steered by a
//                two-stage owner tag. A clear sweep fills the frame with
//                CLR_COLOR, yielding to the display whenever it asks.
//  Ports       : CLK, RST_N          - clock, async active-low reset
//                disp_req/disp_addr  - scan-out pixel request
//                disp_data/disp_dv   - scan-out pixel return
//                wr_valid/wr_ready   - write handshake, wr_addr/wr_data
//                rd_valid/rd_ready   - read handshake, rd_addr
//                rd_data/rd_dv       - read return
//                clr_start/busy      - clear sweep start / in progress
//                mem_addr/mem_we/mem_wdata/mem_rdata - external RAM port
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_mem_arbiter
    import vga_mem_arbiter_pkg::*;
#(
    parameter int                ADDR_W    = c_ADDR_W_DEF,
    parameter int                DATA_W    = c_DATA_W_DEF,
    parameter logic [DATA_W-1:0] CLR_COLOR = '0,
    parameter int                DEPTH     = c_DEPTH_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_dv,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_dv,
    input  logic              clr_start,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   c_DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] clr_ptr_q;
    logic [ADDR_W-1:0] clr_ptr_d;
    owner_tag_e        tag1_q;
    owner_tag_e        tag1_d;
    owner_tag_e        tag2_q;
    logic [DATA_W-1:0] disp_data_q;
    logic [DATA_W-1:0] rd_data_q;

    logic w_arb_en;
    logic w_wr_gnt;
    logic w_rd_gnt;
    logic w_wr_in_range;

    // Write/read only compete for cycles the display and clear leave free.
    // RST_N is folded in so the handshakes drop the instant reset asserts.
    assign w_arb_en      = RST_N & ~disp_req & (state_q == ST_IDLE);
    assign w_wr_in_range = ({1'b0, wr_addr} < c_DEPTH_EXT);

    rr_arb2 u_rr_arb2 (
        .clk_i    (CLK),
        .rst_ni   (RST_N),
        .en_i     (w_arb_en),
        .wr_req_i (wr_valid),
        .rd_req_i (rd_valid),
        .wr_gnt_o (w_wr_gnt),
        .rd_gnt_o (w_rd_gnt)
    );

    // Next-state and RAM command. The RAM command is combinational so a
    // display request reaches the RAM in the same cycle it is raised; all of
    // it is held at zero while RST_N is low.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        tag1_d    = TAG_NONE;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;

        if (RST_N) begin
            if (disp_req) begin
                // Display wins; an active sweep simply holds its pointer.
                mem_addr = disp_addr;
                tag1_d   = TAG_DISP;
            end else if (state_q == ST_CLEAR) begin
                mem_addr  = clr_ptr_q;
                mem_we    = 1'b1;
                mem_wdata = CLR_COLOR;
                if (clr_ptr_q == c_LAST_ADDR) begin
                    state_d   = ST_IDLE;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                end
            end else if (w_wr_gnt) begin
                // Out-of-range writes complete the handshake but never
                // reach the RAM.
                mem_addr  = wr_addr;
                mem_we    = w_wr_in_range;
                mem_wdata = wr_data;
            end else if (w_rd_gnt) begin
                mem_addr = rd_addr;
                tag1_d   = TAG_RD;
            end

            // clr_start is only honoured from IDLE, so a sweep never restarts.
            if ((state_q == ST_IDLE) && clr_start) begin
                state_d   = ST_CLEAR;
                clr_ptr_d = '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // Read return path: tag1 marks the cycle mem_rdata is valid, tag2 marks
    // the cycle the registered data is presented. Reset clears both so no
    // in-flight read can produce a dv pulse afterwards.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tag1_q      <= TAG_NONE;
            tag2_q      <= TAG_NONE;
            disp_data_q <= '0;
            rd_data_q   <= '0;
        end else begin
            tag1_q <= tag1_d;
            tag2_q <= tag1_q;
            if (tag1_q == TAG_DISP) begin
                disp_data_q <= mem_rdata;
            end
            if (tag1_q == TAG_RD) begin
                rd_data_q <= mem_rdata;
            end
        end
    end

    assign disp_data = disp_data_q;
    assign disp_dv   = (tag2_q == TAG_DISP);
    assign rd_data   = rd_data_q;
    assign rd_dv     = (tag2_q == TAG_RD);
    assign wr_ready  = w_wr_gnt;
    assign rd_ready  = w_rd_gnt;
    assign busy      = (state_q == ST_CLEAR);

endmodule : vga_mem_arbiter
`default_nettype wire

// File: tb/tb_vga_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_mem_arbiter
//  Description : Directed scoreboard bench for vga_mem_arbiter with a small
//                behavioural single-port RAM (1-cycle read latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_mem_arbiter;

    localparam int            AW  = 8;
    localparam int            DW  = 8;
    localparam int            DEP = 16;
    localparam logic [DW-1:0] CLR = 8'h3C;

    logic          CLK;
    logic          RST_N;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic [DW-1:0] disp_data;
    logic          disp_dv;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_dv;
    logic          clr_start;
    logic          busy;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    vga_mem_arbiter #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .CLR_COLOR (CLR),
        .DEPTH     (DEP)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .disp_req  (disp_req),
        .disp_addr (disp_addr),
        .disp_data (disp_data),
        .disp_dv   (disp_dv),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_dv     (rd_dv),
        .clr_start (clr_start),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // ---------------- clock, cycle counter, RAM model ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Preload pattern: ram[a] = a ^ 8'h5A, except ram[0x10] = 8'hA5.
    logic [DW-1:0] ram [256];
    initial begin
        for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'h5A;
        ram[16] <= 8'hA5;
    end
    always @(posedge CLK) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // ---------------- scoreboard ----------------
    typedef struct { logic [DW-1:0] data; int cyc; } rexp_t;
    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wexp_t;
    rexp_t dq[$];
    rexp_t rq[$];
    wexp_t wq[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_disp(input logic [DW-1:0] d);
        rexp_t e;
        e.data = d;
        e.cyc  = cyc + 2;
        dq.push_back(e);
    endtask

    task automatic exp_rd(input logic [DW-1:0] d);
        rexp_t e;
        e.data = d;
        e.cyc  = cyc + 2;
        rq.push_back(e);
    endtask

    task automatic exp_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wexp_t e;
        e.addr = a;
        e.data = d;
        wq.push_back(e);
    endtask

    // Monitor: samples just after the falling edge, after the driver has
    // pushed that cycle's expectations.
    initial begin
        rexp_t re;
        wexp_t we;
        forever begin
            @(negedge CLK);
            #2;
            if (disp_dv) begin
                if (dq.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL disp_dv_unexpected: got disp_dv=1, required 0 (cycle %0d)", cyc);
                end else begin
                    re = dq.pop_front();
                    chk("disp_data", 32'(disp_data), 32'(re.data));
                    chk("disp_cycle", 32'(cyc), 32'(re.cyc));
                end
            end
            if (rd_dv) begin
                if (rq.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL rd_dv_unexpected: got rd_dv=1, required 0 (cycle %0d)", cyc);
                end else begin
                    re = rq.pop_front();
                    chk("rd_data", 32'(rd_data), 32'(re.data));
                    chk("rd_cycle", 32'(cyc), 32'(re.cyc));
                end
            end
            if (mem_we) begin
                if (wq.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL mem_we_unexpected: got write 0x%0h@0x%0h, required none (cycle %0d)",
                             mem_wdata, mem_addr, cyc);
                end else begin
                    we = wq.pop_front();
                    chk("mem_wr_addr", 32'(mem_addr), 32'(we.addr));
                    chk("mem_wr_data", 32'(mem_wdata), 32'(we.data));
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic cyc_begin();
        @(posedge CLK);
        #1;
        disp_req  = 1'b0;
        wr_valid  = 1'b0;
        rd_valid  = 1'b0;
        clr_start = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cyc_begin();
        rd_valid = 1'b1;
        rd_addr  = a;
        @(negedge CLK);
        chk("rd_ready_single", 32'(rd_ready), 32'd1);
        if (rd_ready) exp_rd(d);
    endtask

    // Directed tables for the write/read alternation.
    logic [AW-1:0] w_addr_t [3] = '{8'd2, 8'd3, 8'd4};
    logic [DW-1:0] w_data_t [3] = '{8'h11, 8'h22, 8'h33};
    logic [AW-1:0] r_addr_t [3] = '{8'd8, 8'd9, 8'd10};
    logic [DW-1:0] r_exp_t  [3] = '{8'h52, 8'h53, 8'h50};
    logic          gnt_w_t  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    int  wi, ri, bad, busy_cnt;
    logic done, found;

    initial begin
        RST_N = 1'b0;
        disp_req = 1'b1; disp_addr = 8'd5;
        wr_valid = 1'b1; wr_addr = 8'd1; wr_data = 8'hEE;
        rd_valid = 1'b1; rd_addr = 8'd1;
        clr_start = 1'b1;

        // ---- reset state ----
        repeat (2) @(negedge CLK);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_rd_ready", 32'(rd_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_disp_dv", 32'(disp_dv), 32'd0);
        chk("rst_rd_dv", 32'(rd_dv), 32'd0);
        chk("rst_disp_data", 32'(disp_data), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        disp_req = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0; clr_start = 1'b0;
        RST_N = 1'b1;

        // ---- display every 4th cycle at 0x10 ----
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                cyc_begin();
                if (c == 0) begin
                    disp_req  = 1'b1;
                    disp_addr = 8'h10;
                end
                @(negedge CLK);
                if (c == 0) begin
                    chk("disp_mem_addr", 32'(mem_addr), 32'h10);
                    chk("disp_mem_we", 32'(mem_we), 32'd0);
                    exp_disp(8'hA5);
                end
            end
        end

        // ---- write/read alternation, W first ----
        wi = 0; ri = 0;
        for (int k = 0; k < 6; k++) begin
            cyc_begin();
            wr_valid = (wi < 3);
            rd_valid = (ri < 3);
            wr_addr  = w_addr_t[wi % 3];
            wr_data  = w_data_t[wi % 3];
            rd_addr  = r_addr_t[ri % 3];
            @(negedge CLK);
            chk("rr_wr_ready", 32'(wr_ready), 32'(gnt_w_t[k]));
            chk("rr_rd_ready", 32'(rd_ready), 32'(!gnt_w_t[k]));
            if (wr_valid && wr_ready) begin
                exp_wr(w_addr_t[wi], w_data_t[wi]);
                wi++;
            end
            if (rd_valid && rd_ready) begin
                exp_rd(r_exp_t[ri]);
                ri++;
            end
        end
        do_read(8'd2, 8'h11);
        do_read(8'd3, 8'h22);
        do_read(8'd4, 8'h33);

        // ---- 10 display cycles stall a pending write ----
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            cyc_begin();
            disp_req  = 1'b1;
            disp_addr = 8'h20 + 8'(i);
            wr_valid  = 1'b1;
            wr_addr   = 8'd5;
            wr_data   = 8'h77;
            @(negedge CLK);
            if (wr_ready) bad++;
            exp_disp((8'h20 + 8'(i)) ^ 8'h5A);
        end
        chk("wr_ready_under_disp", 32'(bad), 32'd0);
        cyc_begin();
        wr_valid = 1'b1;
        wr_addr  = 8'd5;
        wr_data  = 8'h77;
        @(negedge CLK);
        chk("wr_after_disp_ready", 32'(wr_ready), 32'd1);
        if (wr_ready) exp_wr(8'd5, 8'h77);

        // ---- clear sweep with 4 display cycles and a pending write ----
        for (int i = 0; i < DEP; i++) exp_wr(8'(i), CLR);
        cyc_begin();
        clr_start = 1'b1;
        @(negedge CLK);
        busy_cnt = 0; bad = 0; done = 1'b0;
        for (int j = 1; j <= 40 && !done; j++) begin
            cyc_begin();
            clr_start = (j == 8);
            wr_valid  = 1'b1;
            wr_addr   = 8'd6;
            wr_data   = 8'h66;
            disp_req  = (j == 3) || (j == 6) || (j == 10) || (j == 15);
            disp_addr = 8'h30;
            @(negedge CLK);
            if (disp_req) exp_disp(8'h6A);
            if (!busy) begin
                done = 1'b1;
                chk("clr_pending_wr_ready", 32'(wr_ready), 32'd1);
                if (wr_ready) exp_wr(8'd6, 8'h66);
            end else begin
                busy_cnt++;
                if (wr_ready) bad++;
            end
        end
        chk("clr_done_in_time", 32'(done), 32'd1);
        chk("clr_busy_cycles", 32'(busy_cnt), 32'd20);
        chk("clr_wr_ready_blocked", 32'(bad), 32'd0);
        do_read(8'd0, CLR);
        do_read(8'd15, CLR);
        do_read(8'd2, CLR);
        do_read(8'd6, 8'h66);

        // ---- out-of-range write: handshake, no RAM write ----
        cyc_begin();
        wr_valid = 1'b1;
        wr_addr  = 8'd16;
        wr_data  = 8'h99;
        @(negedge CLK);
        chk("oor_wr_ready", 32'(wr_ready), 32'd1);
        chk("oor_mem_we", 32'(mem_we), 32'd0);
        do_read(8'd16, 8'hA5);

        // ---- reset in the middle of a clear, at pointer 7 ----
        for (int i = 0; i < 8; i++) exp_wr(8'(i), CLR);
        cyc_begin();
        clr_start = 1'b1;
        @(negedge CLK);
        found = 1'b0;
        for (int j = 1; j <= 30 && !found; j++) begin
            cyc_begin();
            disp_req  = (j == 8);
            disp_addr = 8'h30;
            @(negedge CLK);
            if (mem_we && (mem_addr == 8'd7)) found = 1'b1;
        end
        chk("clr_ptr7_reached", 32'(found), 32'd1);
        #3;
        RST_N = 1'b0;
        disp_req = 1'b1; disp_addr = 8'h30;
        wr_valid = 1'b1; wr_addr = 8'd9;
        rd_valid = 1'b1; rd_addr = 8'd9;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_mem_we", 32'(mem_we), 32'd0);
        chk("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("mid_rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("mid_rst_rd_ready", 32'(rd_ready), 32'd0);
        chk("mid_rst_disp_dv", 32'(disp_dv), 32'd0);
        chk("mid_rst_rd_dv", 32'(rd_dv), 32'd0);
        chk("mid_rst_disp_data", 32'(disp_data), 32'd0);
        chk("mid_rst_rd_data", 32'(rd_data), 32'd0);
        repeat (2) @(negedge CLK);
        disp_req = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0;
        RST_N = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            cyc_begin();
            @(negedge CLK);
            if (busy) bad++;
        end
        chk("post_rst_busy_cycles", 32'(bad), 32'd0);

        repeat (3) @(negedge CLK);
        chk("disp_queue_empty", 32'(dq.size()), 32'd0);
        chk("rd_queue_empty", 32'(rq.size()), 32'd0);
        chk("wr_queue_empty", 32'(wq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_vga_mem_arbiter
`default_nettype wire
